// File: rtl/auth_challenge_sequencer.sv
// auth_challenge_sequencer: drives the NLFSR auth core through load/run and returns its response with a watchdog.
module auth_challenge_sequencer #(
  parameter int TIMEOUT_SLACK = 16,
  parameter int CYC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chal_valid,
  output logic             chal_ready,
  input  logic [127:0]     chal_seed,
  input  logic [CYC_W-1:0] chal_cycle,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [127:0]     resp_data,
  output logic             resp_err,
  input  logic             abort,
  output logic             busy,
  output logic [127:0]     seed_top,
  output logic [CYC_W-1:0] cycle,
  output logic             load,
  output logic             cnt_load,
  output logic             start_cnt,
  input  logic [127:0]     out_final,
  input  logic             cnt_done
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;
  state_t           state;
  logic [127:0]     seed_reg;
  logic [CYC_W-1:0] cycle_reg, wd, wd_inc, limit;
  logic [CYC_W:0]   sum;
  // limit saturates so a maximal run length cannot wrap the watchdog
  always_comb begin
    sum = {1'b0, cycle_reg} + (CYC_W+1)'(TIMEOUT_SLACK);
    limit = sum[CYC_W] ? '1 : sum[CYC_W-1:0];
    wd_inc = wd + CYC_W'(1);
  end
  assign seed_top = seed_reg;
  assign cycle = cycle_reg;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      chal_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp_data <= '0;
      resp_err <= 1'b0;
      busy <= 1'b0;
      load <= 1'b0;
      cnt_load <= 1'b0;
      start_cnt <= 1'b0;
      seed_reg <= '0;
      cycle_reg <= '0;
      wd <= '0;
    end else if (abort) begin
      state <= IDLE;
      chal_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp_data <= '0;
      resp_err <= 1'b0;
      busy <= 1'b0;
      load <= 1'b0;
      cnt_load <= 1'b0;
      start_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE: if (chal_valid && chal_ready) begin
          seed_reg <= chal_seed;
          cycle_reg <= chal_cycle;
          chal_ready <= 1'b0;
          busy <= 1'b1;
          if (chal_cycle == '0) begin
            state <= RESP;
            resp_valid <= 1'b1;
            resp_data <= '0;
            resp_err <= 1'b1;
          end else begin
            state <= LOAD;
            load <= 1'b1;
            cnt_load <= 1'b1;
          end
        end
        LOAD: begin
          state <= RUN;
          load <= 1'b0;
          cnt_load <= 1'b0;
          start_cnt <= 1'b1;
          wd <= '0;
        end
        RUN: begin
          wd <= wd_inc;
          if (cnt_done || wd_inc >= limit) begin
            state <= RESP;
            start_cnt <= 1'b0;
            resp_valid <= 1'b1;
            resp_data <= cnt_done ? out_final : '0;
            resp_err <= !cnt_done;
          end
        end
        RESP: if (resp_ready) begin
          state <= IDLE;
          resp_valid <= 1'b0;
          busy <= 1'b0;
          chal_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_auth_challenge_sequencer.sv
// tb_auth_challenge_sequencer: directed checks of the sequencer against a simple counting core model.
module tb_auth_challenge_sequencer;
  logic         clk = 1'b0, rst = 1'b0;
  logic         chal_valid = 1'b0, chal_ready;
  logic [127:0] chal_seed = '0;
  logic [31:0]  chal_cycle = '0;
  logic         resp_valid, resp_ready = 1'b0;
  logic [127:0] resp_data;
  logic         resp_err, abort = 1'b0, busy;
  logic [127:0] seed_top;
  logic [31:0]  cycle;
  logic         load, cnt_load, start_cnt;
  logic [127:0] out_final;
  logic         cnt_done;
  int           checks = 0, errors = 0;
  logic [31:0]  run_cnt = '0;
  int           done_at = 8;
  logic         never_done = 1'b0;

  auth_challenge_sequencer #(.TIMEOUT_SLACK(16), .CYC_W(32)) dut (
    .clk(clk), .rst(rst), .chal_valid(chal_valid), .chal_ready(chal_ready),
    .chal_seed(chal_seed), .chal_cycle(chal_cycle), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .abort(abort), .busy(busy), .seed_top(seed_top), .cycle(cycle), .load(load),
    .cnt_load(cnt_load), .start_cnt(start_cnt), .out_final(out_final), .cnt_done(cnt_done)
  );

  always #5 clk = ~clk;

  // core model: counts run cycles since the counter load; state output mixes in the count
  always @(posedge clk) begin
    if (cnt_load) run_cnt <= '0;
    else if (start_cnt) run_cnt <= run_cnt + 32'd1;
  end
  assign cnt_done = start_cnt && !never_done && (run_cnt == 32'(done_at - 1));
  assign out_final = seed_top ^ {4{run_cnt}};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (chal_ready !== 1'b1) begin errors++; $display("FAIL rst_chal_ready got %0h exp 1", chal_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0h exp 0", busy); end
    checks++; if ({resp_valid, load, cnt_load, start_cnt, resp_err} !== 5'b0) begin errors++; $display("FAIL rst_strobes got %b exp 00000", {resp_valid, load, cnt_load, start_cnt, resp_err}); end
    checks++; if ({resp_data, seed_top, cycle} !== '0) begin errors++; $display("FAIL rst_data got %h/%h/%h exp 0", resp_data, seed_top, cycle); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_normal;
    int loads, starts, n;
    logic [127:0] seed;
    seed = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    done_at = 8; never_done = 1'b0;
    chal_seed = seed; chal_cycle = 32'd8; chal_valid = 1'b1;
    tick();
    chal_valid = 1'b0;
    checks++; if ({load, cnt_load, start_cnt} !== 3'b110) begin errors++; $display("FAIL load_state got %b exp 110", {load, cnt_load, start_cnt}); end
    checks++; if ({chal_ready, busy} !== 2'b01) begin errors++; $display("FAIL load_hs got %b exp 01", {chal_ready, busy}); end
    checks++; if (seed_top !== seed || cycle !== 32'd8) begin errors++; $display("FAIL seed_cycle got %h/%0d exp %h/8", seed_top, cycle, seed); end
    loads = 1; starts = 0; n = 0;
    for (int i = 0; i < 40; i++) begin
      tick(); n++;
      if (load || cnt_load) loads++;
      if (start_cnt) starts++;
      if (resp_valid) break;
    end
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL norm_resp_valid got %0h exp 1", resp_valid); end
    checks++; if (loads !== 1) begin errors++; $display("FAIL norm_load_cycles got %0d exp 1", loads); end
    checks++; if (starts !== 8) begin errors++; $display("FAIL norm_start_cycles got %0d exp 8", starts); end
    checks++; if (n !== 9) begin errors++; $display("FAIL norm_latency got %0d exp 9", n); end
    checks++; if (resp_data !== 128'h0123_4560_89AB_CDE8_FEDC_BA9F_7654_3217) begin errors++; $display("FAIL norm_data got %h exp 0123456089abcde8fedcba9f76543217", resp_data); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL norm_err got %0h exp 0", resp_err); end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checks++; if ({resp_valid, chal_ready, busy} !== 3'b010) begin errors++; $display("FAIL norm_return got %b exp 010", {resp_valid, chal_ready, busy}); end
  endtask

  task automatic test_zero_cycle;
    chal_seed = 128'hDEAD_BEEF; chal_cycle = 32'd0; chal_valid = 1'b1;
    tick();
    chal_valid = 1'b0;
    checks++; if ({resp_valid, resp_err, load, cnt_load, start_cnt} !== 5'b11000) begin errors++; $display("FAIL zero_flags got %b exp 11000", {resp_valid, resp_err, load, cnt_load, start_cnt}); end
    checks++; if (resp_data !== '0) begin errors++; $display("FAIL zero_data got %h exp 0", resp_data); end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checks++; if ({resp_valid, chal_ready} !== 2'b01) begin errors++; $display("FAIL zero_return got %b exp 01", {resp_valid, chal_ready}); end
  endtask

  task automatic test_timeout;
    int starts;
    never_done = 1'b1;
    chal_seed = 128'h5555; chal_cycle = 32'd4; chal_valid = 1'b1;
    tick();
    chal_valid = 1'b0;
    starts = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (start_cnt) starts++;
      if (resp_valid) break;
    end
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL to_resp_valid got %0h exp 1", resp_valid); end
    checks++; if (starts !== 20) begin errors++; $display("FAIL to_start_cycles got %0d exp 20", starts); end
    checks++; if (resp_err !== 1'b1 || resp_data !== '0) begin errors++; $display("FAIL to_result got %0h/%h exp 1/0", resp_err, resp_data); end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    never_done = 1'b0;
  endtask

  task automatic test_abort;
    logic seen;
    done_at = 3;
    chal_seed = 128'h1234; chal_cycle = 32'd3; chal_valid = 1'b1;
    tick();
    chal_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (cnt_done) break;
      tick();
    end
    checks++; if (cnt_done !== 1'b1) begin errors++; $display("FAIL abort_done_seen got %0h exp 1", cnt_done); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if ({chal_ready, busy, start_cnt, resp_valid} !== 4'b1000) begin errors++; $display("FAIL abort_state got %b exp 1000", {chal_ready, busy, start_cnt, resp_valid}); end
    checks++; if (resp_data !== '0 || resp_err !== 1'b0) begin errors++; $display("FAIL abort_resp got %h/%0h exp 0/0", resp_data, resp_err); end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= resp_valid;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_resp got %0h exp 0", seen); end
  endtask

  task automatic test_hold;
    done_at = 5;
    chal_seed = 128'hAAAA_0000_BBBB_0000_CCCC_0000_DDDD_0000; chal_cycle = 32'd5; chal_valid = 1'b1;
    tick();
    chal_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (resp_valid) break;
    end
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL hold_resp_valid got %0h exp 1", resp_valid); end
    checks++; if (resp_data !== 128'hAAAA_0004_BBBB_0004_CCCC_0004_DDDD_0004) begin errors++; $display("FAIL hold_data got %h exp aaaa0004bbbb0004cccc0004dddd0004", resp_data); end
    chal_cycle = 32'd99;
    for (int i = 0; i < 10; i++) begin
      chal_valid = (i == 3);
      tick();
      checks++; if ({resp_valid, chal_ready} !== 2'b10) begin errors++; $display("FAIL hold_hs_%0d got %b exp 10", i, {resp_valid, chal_ready}); end
      checks++; if (resp_data !== 128'hAAAA_0004_BBBB_0004_CCCC_0004_DDDD_0004) begin errors++; $display("FAIL hold_stable_%0d got %h", i, resp_data); end
    end
    chal_valid = 1'b0;
    checks++; if (cycle !== 32'd5) begin errors++; $display("FAIL hold_ignored got %0d exp 5", cycle); end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checks++; if ({resp_valid, chal_ready} !== 2'b01) begin errors++; $display("FAIL hold_return got %b exp 01", {resp_valid, chal_ready}); end
  endtask

  task automatic test_async_reset;
    done_at = 8;
    chal_seed = 128'h7777; chal_cycle = 32'd8; chal_valid = 1'b1;
    tick();
    chal_valid = 1'b0;
    tick(); tick(); tick();
    checks++; if (start_cnt !== 1'b1) begin errors++; $display("FAIL ar_running got %0h exp 1", start_cnt); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({start_cnt, busy} !== 2'b00) begin errors++; $display("FAIL ar_immediate got %b exp 00", {start_cnt, busy}); end
    checks++; if (resp_data !== '0) begin errors++; $display("FAIL ar_resp_data got %h exp 0", resp_data); end
    #2 rst = 1'b1;
    tick();
    checks++; if ({chal_ready, busy, resp_valid} !== 3'b100) begin errors++; $display("FAIL ar_release got %b exp 100", {chal_ready, busy, resp_valid}); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_zero_cycle();
    test_timeout();
    test_abort();
    test_hold();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
